// File: rtl/mdu_divider.sv
// Radix-2 restoring divider for DIV/DIVU. Produces LO (quotient) and HI
// (remainder) after WIDTH subtract steps plus one sign-fixup cycle.
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    shift_r, trial;

  // Operand magnitudes and the per-step trial subtraction.
  always_comb begin
    a_neg   = is_signed & dividend[WIDTH-1];
    b_neg   = is_signed & divisor[WIDTH-1];
    abs_a   = a_neg ? (~dividend + 1'b1) : dividend;
    abs_b   = b_neg ? (~divisor + 1'b1) : divisor;
    // Partial remainder after shifting in the next dividend bit; the extra
    // bit keeps 2R+1 from overflowing, and trial[WIDTH] is the borrow.
    shift_r = {r_q, q_q[WIDTH-1]};
    trial   = shift_r - {1'b0, dvsr_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero completes immediately with the raw dividend.
            quot_d  = '1;
            rem_d   = dividend;
            state_d = StDone;
          end else begin
            r_d     = '0;
            q_d     = abs_a;
            dvsr_d  = abs_b;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shift_r[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        quot_d  = neg_q_q ? (~q_q + 1'b1) : q_q;
        rem_d   = neg_r_q ? (~r_q + 1'b1) : r_q;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything and leaves the published result untouched.
    if (flush) begin
      state_d = StIdle;
      r_d     = r_q;
      q_d     = q_q;
      dvsr_d  = dvsr_q;
      cnt_d   = cnt_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // Status and result outputs.
  always_comb begin
    busy      = (state_q == StCalc) || (state_q == StFix);
    done      = (state_q == StDone);
    quotient  = quot_q;
    remainder = rem_q;
  end

endmodule
